// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave):
// a single outstanding request completed by a one-cycle ack.
interface mem_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wstrb_o;
  logic        dmem_ack_i;
  logic [63:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_stage.sv
// rv64IM memory-access stage: loads/stores over a req/ack bus with lane steering,
// load extension, misalignment detection and a timeout for hung accesses.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  rf_rd_i,
  input  logic        rf_wen_i,
  input  logic [63:0] aluout_i,
  input  logic [63:0] pc_i,
  input  logic        exit_i,
  input  logic [3:0]  mem_op_i,
  input  logic [63:0] store_data_i,
  output logic        stall_o,
  mem_stage_if.master dmem,
  output logic        valid_o,
  output logic [4:0]  rf_rd_o,
  output logic        rf_wen_o,
  output logic [63:0] rf_wdata_o,
  output logic [63:0] pc_o,
  output logic        exit_o,
  output logic        err_o
);
  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // Access size: 0 byte, 1 half, 2 word, 3 doubleword.
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      4'd2, 4'd6, 4'd9:  op_size = 2'd1;
      4'd3, 4'd7, 4'd10: op_size = 2'd2;
      4'd4, 4'd11:       op_size = 2'd3;
      default:           op_size = 2'd0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [3:0] op);
    is_mem = (op >= 4'd1) && (op <= 4'd11);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    is_store = (op >= 4'd8) && (op <= 4'd11);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [2:0] off);
    case (op_size(op))
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      2'd3:    misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] store_strb(input logic [3:0] op, input logic [2:0] off);
    logic [7:0] base;
    case (op_size(op))
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    store_strb = is_store(op) ? (base << off) : 8'h00;
  endfunction

  function automatic logic [63:0] load_extract(input logic [3:0] op, input logic [2:0] off,
                                               input logic [63:0] rdata);
    logic [63:0] sh;
    sh = rdata >> {off, 3'b000};
    case (op)
      4'd1:    load_extract = {{56{sh[7]}}, sh[7:0]};
      4'd2:    load_extract = {{48{sh[15]}}, sh[15:0]};
      4'd3:    load_extract = {{32{sh[31]}}, sh[31:0]};
      4'd5:    load_extract = {56'd0, sh[7:0]};
      4'd6:    load_extract = {48'd0, sh[15:0]};
      4'd7:    load_extract = {32'd0, sh[31:0]};
      default: load_extract = rdata;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        accept, retire, ret_err, ret_wen;
  logic [4:0]  ret_rd;
  logic [63:0] ret_wdata, ret_pc;
  logic        ret_exit;

  logic [4:0]  rd_p1;
  logic        wen_p1, exit_p1, we_p1;
  logic [63:0] alu_p1, pc_p1, wdata_p1;
  logic [3:0]  op_p1;
  logic [7:0]  wstrb_p1;
  logic        wen_p2;

  assign accept = (state_q == IDLE) && valid_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = 8'd0;
    retire    = 1'b0;
    ret_err   = 1'b0;
    ret_rd    = rd_p1;
    ret_wen   = wen_p1;
    ret_wdata = alu_p1;
    ret_pc    = pc_p1;
    ret_exit  = exit_p1;
    case (state_q)
      IDLE: begin
        ret_rd    = rf_rd_i;
        ret_wen   = rf_wen_i;
        ret_wdata = aluout_i;
        ret_pc    = pc_i;
        ret_exit  = exit_i;
        if (valid_i) begin
          if (!is_mem(mem_op_i)) begin
            retire = 1'b1;
          end else if (misaligned(mem_op_i, aluout_i[2:0])) begin
            retire  = 1'b1;
            ret_err = 1'b1;
            ret_wen = 1'b0;
          end else begin
            state_d = REQ;
          end
        end
      end
      default: begin
        // An ack arriving on the last permitted cycle still completes normally.
        if (dmem.dmem_ack_i) begin
          retire  = 1'b1;
          state_d = IDLE;
          if (is_store(op_p1)) ret_wen = 1'b0;
          else ret_wdata = load_extract(op_p1, alu_p1[2:0], dmem.dmem_rdata_i);
        end else if (cnt_q == CNT_LAST) begin
          retire  = 1'b1;
          ret_err = 1'b1;
          ret_wen = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  // p1: bundle captured on acceptance, holds the bus request stable while in REQ
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_p1    <= rf_rd_i;
      wen_p1   <= rf_wen_i;
      alu_p1   <= aluout_i;
      pc_p1    <= pc_i;
      exit_p1  <= exit_i;
      op_p1    <= mem_op_i;
      we_p1    <= is_store(mem_op_i);
      wdata_p1 <= store_data_i << {aluout_i[2:0], 3'b000};
      wstrb_p1 <= store_strb(mem_op_i, aluout_i[2:0]);
    end
  end

  // p2: retirement bundle handed to writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      valid_o    <= 1'b0;
      err_o      <= 1'b0;
      wen_p2     <= 1'b0;
      rf_rd_o    <= 5'd0;
      rf_wdata_o <= 64'd0;
      pc_o       <= 64'd0;
      exit_o     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_o <= retire;
      err_o   <= ret_err;
      if (retire) begin
        wen_p2     <= ret_wen;
        rf_rd_o    <= ret_rd;
        rf_wdata_o <= ret_wdata;
        pc_o       <= ret_pc;
        exit_o     <= ret_exit;
      end
    end
  end

  assign rf_wen_o          = valid_o & wen_p2;
  assign stall_o           = (state_q == REQ);
  assign dmem.dmem_req_o   = (state_q == REQ);
  assign dmem.dmem_we_o    = we_p1;
  assign dmem.dmem_addr_o  = {alu_p1[63:3], 3'b000};
  assign dmem.dmem_wdata_o = wdata_p1;
  assign dmem.dmem_wstrb_o = wstrb_p1;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-instruction vectors plus
// hand-written timeout, reset-abort, idle-ack and back-to-back sequences.
module tb_mem_stage;
  logic        clk, rst, valid_i, rf_wen_i, exit_i, stall_o;
  logic [4:0]  rf_rd_i, rf_rd_o;
  logic [63:0] aluout_i, pc_i, store_data_i;
  logic [3:0]  mem_op_i;
  logic        valid_o, rf_wen_o, exit_o, err_o;
  logic [63:0] rf_wdata_o, pc_o;
  int          checks, passes;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .rf_rd_i(rf_rd_i), .rf_wen_i(rf_wen_i),
    .aluout_i(aluout_i), .pc_i(pc_i), .exit_i(exit_i), .mem_op_i(mem_op_i),
    .store_data_i(store_data_i), .stall_o(stall_o), .dmem(bus.master),
    .valid_o(valid_o), .rf_rd_o(rf_rd_o), .rf_wen_o(rf_wen_o), .rf_wdata_o(rf_wdata_o),
    .pc_o(pc_o), .exit_o(exit_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [63:0] rdata;
    int          dly;
    logic        req;
    logic [7:0]  strb;
    logic [63:0] bwdata;
    logic [63:0] wdata;
    logic        wen;
    logic        err;
  } vec_t;

  localparam int NV = 14;
  vec_t v[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic present(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] sd,
                         input logic [4:0] rd, input logic [63:0] pc);
    valid_i = 1'b1; mem_op_i = op; aluout_i = addr; store_data_i = sd;
    rf_rd_i = rd; rf_wen_i = 1'b1; pc_i = pc; exit_i = 1'b0;
  endtask

  initial begin
    int nst, n;
    checks = 0; passes = 0;
    rst = 1'b1; valid_i = 1'b0; rf_rd_i = '0; rf_wen_i = 1'b0; aluout_i = '0; pc_i = '0;
    exit_i = 1'b0; mem_op_i = '0; store_data_i = '0;
    bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = '0;

    //        op     addr              sdata                  rdata                  dly req strb   bus wdata              rf_wdata               wen err
    v[0]  = '{4'd0,  64'h1234, 64'h0,                  64'h0,                  0, 0, 8'h00, 64'h0,                  64'h1234,              1, 0};
    v[1]  = '{4'd1,  64'h1003, 64'h0,                  64'h0000_0000_8000_0000, 0, 1, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 1, 0};
    v[2]  = '{4'd5,  64'h1003, 64'h0,                  64'h0000_0000_8000_0000, 1, 1, 8'h00, 64'h0,                 64'h80,                1, 0};
    v[3]  = '{4'd9,  64'h2006, 64'hABCD,               64'h0,                  3, 1, 8'hC0, 64'hABCD_0000_0000_0000, 64'h2006,             0, 0};
    v[4]  = '{4'd3,  64'h3002, 64'h0,                  64'h0,                  0, 0, 8'h00, 64'h0,                  64'h3002,              0, 1};
    v[5]  = '{4'd2,  64'h4002, 64'h0,                  64'h0000_0000_F00D_0000, 1, 1, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_F00D, 1, 0};
    v[6]  = '{4'd7,  64'h5004, 64'h0,                  64'h8765_4321_0000_0000, 0, 1, 8'h00, 64'h0,                 64'h8765_4321,         1, 0};
    v[7]  = '{4'd3,  64'h5004, 64'h0,                  64'h8765_4321_0000_0000, 0, 1, 8'h00, 64'h0,                 64'hFFFF_FFFF_8765_4321, 1, 0};
    v[8]  = '{4'd4,  64'h6000, 64'h0,                  64'h0123_4567_89AB_CDEF, 2, 1, 8'h00, 64'h0,                 64'h0123_4567_89AB_CDEF, 1, 0};
    v[9]  = '{4'd11, 64'h7001, 64'h55,                 64'h0,                  0, 0, 8'h00, 64'h0,                  64'h7001,              0, 1};
    v[10] = '{4'd8,  64'h7005, 64'hFFFF_FFFF_FFFF_FF5A, 64'h0,                 0, 1, 8'h20, 64'hFFFF_5A00_0000_0000, 64'h7005,             0, 0};
    v[11] = '{4'd10, 64'h7004, 64'h1122_3344_5566_7788, 64'h0,                 1, 1, 8'hF0, 64'h5566_7788_0000_0000, 64'h7004,             0, 0};
    v[12] = '{4'd13, 64'hDEAD, 64'h0,                  64'h0,                  0, 0, 8'h00, 64'h0,                  64'hDEAD,              1, 0};
    v[13] = '{4'd6,  64'h4006, 64'h0,                  64'hBEEF_0000_0000_0000, 0, 1, 8'h00, 64'h0,                 64'hBEEF,              1, 0};

    repeat (3) step();
    chk("rst_valid", valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_wen", rf_wen_o, 0);
    chk("rst_wdata", rf_wdata_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_rd", rf_rd_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_req", bus.dmem_req_o, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      present(v[i].op, v[i].addr, v[i].sdata, 5'(i + 1), 64'h1000 + 64'(i * 4));
      exit_i = i[0];
      step();
      valid_i = 1'b0;
      if (v[i].req) begin
        chk("req", bus.dmem_req_o, 1);
        chk("addr", bus.dmem_addr_o, v[i].addr & ~64'h7);
        chk("wstrb", bus.dmem_wstrb_o, v[i].strb);
        chk("we", bus.dmem_we_o, v[i].strb != 8'h00);
        if (v[i].strb != 8'h00) chk("bus_wdata", bus.dmem_wdata_o, v[i].bwdata);
        nst = 0;
        for (int c = 0; c < v[i].dly; c++) begin
          nst += int'(stall_o);
          step();
        end
        nst += int'(stall_o);
        bus.dmem_rdata_i = v[i].rdata;
        bus.dmem_ack_i = 1'b1;
        step();
        bus.dmem_ack_i = 1'b0;
        bus.dmem_rdata_i = '0;
        chk("stall_cycles", 64'(nst), 64'(v[i].dly + 1));
      end else begin
        chk("no_req", bus.dmem_req_o, 0);
        chk("no_stall", stall_o, 0);
      end
      chk("valid", valid_o, 1);
      chk("rf_wdata", rf_wdata_o, v[i].wdata);
      chk("rf_wen", rf_wen_o, v[i].wen);
      chk("err", err_o, v[i].err);
      chk("rf_rd", rf_rd_o, 64'(i + 1));
      chk("pc", pc_o, 64'h1000 + 64'(i * 4));
      chk("exit", exit_o, i[0]);
      step();
      chk("valid_pulse", valid_o, 0);
      chk("wen_idle", rf_wen_o, 0);
    end

    // Timeout: LD with no ack holds req for TIMEOUT cycles then retires with err.
    present(4'd4, 64'h8000, 64'h0, 5'd7, 64'h2000);
    step();
    valid_i = 1'b0;
    n = 0;
    while (bus.dmem_req_o && n < 20) begin
      n++;
      step();
    end
    chk("timeout_req_cycles", 64'(n), 4);
    chk("timeout_valid", valid_o, 1);
    chk("timeout_err", err_o, 1);
    chk("timeout_wen", rf_wen_o, 0);
    step();
    chk("timeout_pulse", valid_o, 0);

    // Reset during REQ abandons the access without retiring it.
    present(4'd4, 64'h8008, 64'h0, 5'd8, 64'h3000);
    step();
    valid_i = 1'b0;
    step();
    chk("abort_req_before", bus.dmem_req_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_req", bus.dmem_req_o, 0);
    chk("abort_valid", valid_o, 0);
    chk("abort_stall", stall_o, 0);
    step();
    chk("abort_no_retire", valid_o, 0);

    // Stray ack in IDLE is ignored.
    bus.dmem_ack_i = 1'b1;
    step();
    bus.dmem_ack_i = 1'b0;
    chk("idle_ack_valid", valid_o, 0);
    chk("idle_ack_req", bus.dmem_req_o, 0);

    // Back-to-back ADD, LD (ack after one REQ cycle), ADD.
    present(4'd0, 64'h11, 64'h0, 5'd1, 64'h100);
    step();
    chk("b2b_add1_valid", valid_o, 1);
    chk("b2b_add1_pc", pc_o, 64'h100);
    chk("b2b_add1_stall", stall_o, 0);
    present(4'd4, 64'h9000, 64'h0, 5'd2, 64'h104);
    step();
    chk("b2b_ld_stall", stall_o, 1);
    chk("b2b_ld_gap", valid_o, 0);
    present(4'd0, 64'h33, 64'h0, 5'd3, 64'h108);
    bus.dmem_rdata_i = 64'hCAFE_F00D_1234_5678;
    bus.dmem_ack_i = 1'b1;
    step();
    bus.dmem_ack_i = 1'b0;
    chk("b2b_ld_valid", valid_o, 1);
    chk("b2b_ld_pc", pc_o, 64'h104);
    chk("b2b_ld_data", rf_wdata_o, 64'hCAFE_F00D_1234_5678);
    chk("b2b_ld_stall_after", stall_o, 0);
    step();
    valid_i = 1'b0;
    chk("b2b_add2_valid", valid_o, 1);
    chk("b2b_add2_pc", pc_o, 64'h108);
    chk("b2b_add2_data", rf_wdata_o, 64'h33);
    chk("b2b_add2_stall", stall_o, 0);
    step();
    chk("b2b_end", valid_o, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
